// File: rtl/wb_lsu_master.sv
// Wishbone initiator for core loads/stores: one bus cycle per request, lane steering,
// load extension, misalignment trap. Optional abort timer under WB_MASTER_TIMEOUT_EN.
module wb_lsu_master #(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic              o_busy,
  output logic              o_done,
  output logic [31:0]       o_rdata,
  output logic              o_misaligned,
  output logic              o_timeout,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [31:0]       o_wb_data,
  output logic [3:0]        o_wb_sel,
  input  logic              i_wb_ack,
  input  logic              i_wb_stall,
  input  logic [31:0]       i_wb_data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, MISAL} state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic        uns_q;

  logic        aligned;
  logic [3:0]  sel_lanes;
  logic [31:0] data_lanes;
  logic [31:0] lane;
  logic [31:0] load_val;
  logic        ack_ok;
  logic        tmo_hit;
  logic        abort;

  always_comb begin
    aligned    = 1'b1;
    sel_lanes  = 4'b1111;
    data_lanes = i_wdata;
    case (i_size)
      2'b00: begin
        sel_lanes  = 4'b0001 << i_addr[1:0];
        data_lanes = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        aligned    = ~i_addr[0];
        sel_lanes  = 4'b0011 << {i_addr[1], 1'b0};
        data_lanes = {2{i_wdata[15:0]}};
      end
      default: aligned = (i_addr[1:0] == 2'b00);
    endcase
  end

  // The latched bus address selects the lane, so extraction follows the request, not the core.
  always_comb begin
    lane     = i_wb_data;
    load_val = i_wb_data;
    case (size_q)
      2'b00: begin
        lane     = i_wb_data >> {o_wb_addr[1:0], 3'b000};
        load_val = {{24{~uns_q & lane[7]}}, lane[7:0]};
      end
      2'b01: begin
        lane     = i_wb_data >> {o_wb_addr[1], 4'b0000};
        load_val = {{16{~uns_q & lane[15]}}, lane[15:0]};
      end
      default: ;
    endcase
  end

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || state == IDLE || state == MISAL) tmo_cnt <= '0;
    else                                          tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Acks only count once the strobe has been accepted; an ack on the limit cycle wins.
  assign ack_ok = ((state == REQ) && !i_wb_stall && i_wb_ack) ||
                  ((state == WAIT) && i_wb_ack);
  assign abort  = ((state == REQ) || (state == WAIT)) && !ack_ok && tmo_hit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_rdata      <= '0;
      o_misaligned <= 1'b0;
      o_timeout    <= 1'b0;
      o_wb_cyc     <= 1'b0;
      o_wb_stb     <= 1'b0;
      o_wb_we      <= 1'b0;
      o_wb_addr    <= '0;
      o_wb_data    <= '0;
      o_wb_sel     <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
    end else begin
      o_done       <= 1'b0;
      o_misaligned <= 1'b0;
      o_timeout    <= 1'b0;
      if (ack_ok || abort) begin
        state     <= IDLE;
        o_busy    <= 1'b0;
        o_wb_cyc  <= 1'b0;
        o_wb_stb  <= 1'b0;
        o_done    <= 1'b1;
        o_timeout <= abort;
        if (ack_ok && !o_wb_we) o_rdata <= load_val;
      end else begin
        case (state)
          IDLE: begin
            if (i_req) begin
              o_busy <= 1'b1;
              if (aligned) begin
                state     <= REQ;
                o_wb_cyc  <= 1'b1;
                o_wb_stb  <= 1'b1;
                o_wb_we   <= i_we;
                o_wb_addr <= i_addr;
                o_wb_data <= data_lanes;
                o_wb_sel  <= sel_lanes;
                size_q    <= i_size;
                uns_q     <= i_unsigned;
              end else begin
                state        <= MISAL;
                o_done       <= 1'b1;
                o_misaligned <= 1'b1;
              end
            end
          end
          MISAL: begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
          REQ: begin
            if (!i_wb_stall) begin
              state    <= WAIT;
              o_wb_stb <= 1'b0;
            end
          end
          WAIT: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Bench for wb_lsu_master: pipelined memory slave model with stall/ack controls,
// expected load results queued at issue and popped on o_done.
module tb_wb_lsu_master;
  localparam int ADDR_W = 10;
`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 255;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req, we, uns;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [1:0]        size;
  logic              busy, done, mis, tmo;
  logic [31:0]       rdata;
  logic              wb_cyc, wb_stb, wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [31:0]       wb_wdat;
  logic [3:0]        wb_sel;
  logic              wb_ack, wb_stall;
  logic [31:0]       wb_rdat;

  logic              mem_load, stall_on, ack_en, force_ack, slv_ack;
  logic [31:0]       mem [0:255];

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  wb_lsu_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .i_size(size), .i_unsigned(uns),
    .o_busy(busy), .o_done(done), .o_rdata(rdata), .o_misaligned(mis),
    .o_timeout(tmo), .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
    .o_wb_addr(wb_addr), .o_wb_data(wb_wdat), .o_wb_sel(wb_sel),
    .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_data(wb_rdat)
  );

  assign wb_ack   = slv_ack | force_ack;
  assign wb_stall = stall_on;

  // Slave: accepts an unstalled strobe and acks with data one cycle later.
  always @(posedge clk) begin
    slv_ack <= 1'b0;
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h80FF1234;
    end else if (wb_cyc && wb_stb && !wb_stall && ack_en) begin
      slv_ack <= 1'b1;
      wb_rdat <= mem[wb_addr[9:2]];
      if (wb_we)
        for (int k = 0; k < 4; k++)
          if (wb_sel[k]) mem[wb_addr[9:2]][8*k +: 8] <= wb_wdat[8*k +: 8];
    end
  end

  task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic u);
    req = 1'b1; we = w; addr = a; wdata = d; size = s; uns = u;
    @(negedge clk);
    req = 1'b0;
  endtask

  // lat counts edges from the accepting edge to the first cycle with done high.
  task automatic wait_done(output int lat, output int cyc_hi, output bit ok);
    lat = 1; cyc_hi = 0; ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      if (wb_cyc === 1'b1) cyc_hi++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; size = '0; uns = 1'b0;
    stall_on = 1'b0; ack_en = 1'b1; force_ack = 1'b0; mem_load = 1'b1;
    repeat (3) @(negedge clk);
    mem_load = 1'b0;
    n_tests++;
    if ({busy, done, mis, tmo, wb_cyc, wb_stb, wb_we} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000000", {busy, done, mis, tmo, wb_cyc, wb_stb, wb_we});
    end
    n_tests++;
    if ({rdata, wb_wdat, wb_addr, wb_sel} !== '0) begin
      n_fail++; $display("FAIL reset_data: rdata %h wbdata %h addr %h sel %b want all 0", rdata, wb_wdat, wb_addr, wb_sel);
    end
    rst = 1'b0;
    last_rd = 32'h0;
    @(negedge clk);
  endtask

  // Loads back-to-back: each next request is issued in the cycle done is high.
  task automatic test_load;
    logic [9:0]  la [4] = '{10'h007, 10'h007, 10'h006, 10'h004};
    logic [1:0]  ls [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
    logic        lu [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] le [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h80FF1234};
    logic [3:0]  lsel [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b1111};
    int lat, ch; bit ok; logic [31:0] e;
    for (int t = 0; t < 4; t++) begin
      issue(1'b0, la[t], 32'h0, ls[t], lu[t]);
      exp_q.push_back(le[t]);
      n_tests++;
      if ({wb_cyc, wb_stb, wb_we} !== 3'b110 || wb_sel !== lsel[t] || wb_addr !== la[t]) begin
        n_fail++; $display("FAIL load_bus[%0d]: cyc/stb/we %b sel %b addr %h want 110 %b %h",
                           t, {wb_cyc, wb_stb, wb_we}, wb_sel, wb_addr, lsel[t], la[t]);
      end
      wait_done(lat, ch, ok);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || lat != 3 || rdata !== e || mis !== 1'b0) begin
        n_fail++; $display("FAIL load_data[%0d]: ok %0d lat %0d rdata %h mis %b want lat 3 rdata %h mis 0",
                           t, ok, lat, rdata, mis, e);
      end
      last_rd = e;
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL load_single_done: done %b busy %b want 0 0", done, busy);
    end
  endtask

  task automatic test_store;
    logic        sw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [9:0]  sa [4] = '{10'h006, 10'h004, 10'h005, 10'h005};
    logic [31:0] sd [4] = '{32'h0000ABCD, 32'h0, 32'h000000EE, 32'h0};
    logic [1:0]  ss [4] = '{2'b01, 2'b10, 2'b00, 2'b00};
    logic [3:0]  sel [4] = '{4'b1100, 4'b1111, 4'b0010, 4'b0010};
    logic [31:0] bd [4] = '{32'hABCDABCD, 32'h0, 32'hEEEEEEEE, 32'h0};
    logic [31:0] le [4] = '{32'h0, 32'hABCD1234, 32'h0, 32'hFFFFFFEE};
    int lat, ch; bit ok; logic [31:0] e;
    for (int t = 0; t < 4; t++) begin
      issue(sw[t], sa[t], sd[t], ss[t], 1'b0);
      if (sw[t]) begin
        e = last_rd;
        n_tests++;
        if (wb_we !== 1'b1 || wb_sel !== sel[t] || wb_wdat !== bd[t]) begin
          n_fail++; $display("FAIL store_bus[%0d]: we %b sel %b data %h want 1 %b %h",
                             t, wb_we, wb_sel, wb_wdat, sel[t], bd[t]);
        end
      end else begin
        exp_q.push_back(le[t]);
        e = 32'h0;
      end
      wait_done(lat, ch, ok);
      if (!sw[t]) begin
        e = exp_q.pop_front();
        last_rd = e;
      end
      n_tests++;
      if (!ok || lat != 3 || rdata !== e) begin
        n_fail++; $display("FAIL store_result[%0d]: ok %0d lat %0d rdata %h want lat 3 rdata %h", t, ok, lat, rdata, e);
      end
    end
  endtask

  task automatic test_misaligned;
    logic [9:0] ma [2] = '{10'h002, 10'h001};
    logic [1:0] ms [2] = '{2'b10, 2'b01};
    int lat, ch; bit ok;
    for (int t = 0; t < 2; t++) begin
      issue(1'b0, ma[t], 32'h0, ms[t], 1'b0);
      wait_done(lat, ch, ok);
      n_tests++;
      if (!ok || lat != 1 || mis !== 1'b1 || tmo !== 1'b0 || wb_cyc !== 1'b0 || ch != 0 || rdata !== last_rd) begin
        n_fail++; $display("FAIL misaligned[%0d]: ok %0d lat %0d mis %b tmo %b cyc %b rdata %h want lat 1 mis 1 tmo 0 cyc 0 rdata %h",
                           t, ok, lat, mis, tmo, wb_cyc, rdata, last_rd);
      end
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || mis !== 1'b0 || busy !== 1'b0 || wb_cyc !== 1'b0) begin
        n_fail++; $display("FAIL misaligned_end[%0d]: done %b mis %b busy %b cyc %b want 0 0 0 0", t, done, mis, busy, wb_cyc);
      end
    end
  endtask

  task automatic test_stall;
    int lat, ch; bit ok; logic [31:0] e;
    stall_on = 1'b1;
    issue(1'b0, 10'h004, 32'h0, 2'b10, 1'b0);
    exp_q.push_back(32'hABCDEE34);
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if ({wb_cyc, wb_stb} !== 2'b11 || wb_addr !== 10'h004 || wb_sel !== 4'b1111) begin
        n_fail++; $display("FAIL stall_hold[%0d]: cyc/stb %b addr %h sel %b want 11 004 1111", c, {wb_cyc, wb_stb}, wb_addr, wb_sel);
      end
      if (c == 0) begin req = 1'b1; addr = 10'h001; size = 2'b01; end
      if (c == 1) req = 1'b0;
      if (c == 3) stall_on = 1'b0;
      @(negedge clk);
    end
    wait_done(lat, ch, ok);
    e = exp_q.pop_front();
    last_rd = e;
    n_tests++;
    if (!ok || lat != 2 || rdata !== e || mis !== 1'b0) begin
      n_fail++; $display("FAIL stall_done: ok %0d wait %0d rdata %h mis %b want wait 2 rdata %h mis 0", ok, lat, rdata, mis, e);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0 || wb_cyc !== 1'b0) begin
        n_fail++; $display("FAIL stall_no_queue[%0d]: done %b busy %b cyc %b want 0 0 0", c, done, busy, wb_cyc);
      end
    end
  endtask

  task automatic test_timeout;
    int lat, ch; bit ok;
    ack_en = 1'b0;
    issue(1'b0, 10'h004, 32'h0, 2'b10, 1'b0);
`ifdef WB_MASTER_TIMEOUT_EN
    wait_done(lat, ch, ok);
    n_tests++;
    if (!ok || tmo !== 1'b1 || wb_cyc !== 1'b0 || ch != TMO || rdata !== last_rd) begin
      n_fail++; $display("FAIL timeout: ok %0d tmo %b cyc %b cyc_cycles %0d rdata %h want tmo 1 cyc 0 cycles %0d rdata %h",
                         ok, tmo, wb_cyc, ch, rdata, TMO, last_rd);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || tmo !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_end: done %b tmo %b busy %b want 0 0 0", done, tmo, busy);
    end
    ack_en = 1'b1;
`else
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1 || tmo === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (ok || busy !== 1'b1 || wb_cyc !== 1'b1) begin
      n_fail++; $display("FAIL no_timeout: early_done %0d busy %b cyc %b want 0 1 1", ok, busy, wb_cyc);
    end
    lat = 0; ch = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1;
    last_rd = 32'h0;
`endif
  endtask

  task automatic test_reset_mid;
    int lat, ch; bit ok; logic [31:0] e;
    ack_en = 1'b0;
    issue(1'b0, 10'h004, 32'h0, 2'b10, 1'b0);
    @(negedge clk);
    n_tests++;
    if ({wb_cyc, wb_stb, busy} !== 3'b101) begin
      n_fail++; $display("FAIL rst_mid_wait: cyc/stb/busy %b want 101", {wb_cyc, wb_stb, busy});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd = 32'h0;
    n_tests++;
    if ({wb_cyc, wb_stb, busy, done} !== 4'b0 || rdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid: cyc/stb/busy/done %b rdata %h want 0000 0", {wb_cyc, wb_stb, busy, done}, rdata);
    end
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    n_tests++;
    if ({wb_cyc, busy, done} !== 3'b0 || rdata !== 32'h0) begin
      n_fail++; $display("FAIL late_ack: cyc/busy/done %b rdata %h want 000 0", {wb_cyc, busy, done}, rdata);
    end
    ack_en = 1'b1;
    issue(1'b0, 10'h004, 32'h0, 2'b10, 1'b0);
    exp_q.push_back(32'hABCDEE34);
    wait_done(lat, ch, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || lat != 3 || rdata !== e || tmo !== 1'b0) begin
      n_fail++; $display("FAIL after_rst_load: ok %0d lat %0d rdata %h tmo %b want lat 3 rdata %h tmo 0", ok, lat, rdata, tmo, e);
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_store;
    test_misaligned;
    test_stall;
    test_timeout;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
